// File: rtl/mem_map_pkg.sv
// Address map, register bit layout and region decode type for the
// data-memory responder.
package mem_map_pkg;

   localparam logic [23:0] FIFO_DATA_ADDR = 24'h800000;
   localparam logic [23:0] STATUS_ADDR    = 24'h800004;
   localparam logic [23:0] CYCLES_ADDR    = 24'h800008;
   localparam logic [23:0] CTRL_ADDR      = 24'h80000C;

   localparam int STATUS_OVF_BIT   = 23;
   localparam int STATUS_FULL_BIT  = 22;
   localparam int STATUS_EMPTY_BIT = 21;
   localparam int STATUS_COUNT_W   = 8;

   localparam int CTRL_CLR_OVF_BIT = 0;
   localparam int CTRL_FLUSH_BIT   = 1;

   typedef enum logic [2:0] {
      REG_RAM    = 3'd0,
      REG_FIFO   = 3'd1,
      REG_STATUS = 3'd2,
      REG_CYCLES = 3'd3,
      REG_CTRL   = 3'd4,
      REG_NONE   = 3'd5
   } region_e;

   // Assembles the STATUS word; unused bits stay zero.
   function automatic logic [23:0] pack_status(
      input logic                      ovf,
      input logic                      full,
      input logic                      empty,
      input logic [STATUS_COUNT_W-1:0] count
   );
      logic [23:0] w_word;
      w_word                   = 24'h000000;
      w_word[STATUS_OVF_BIT]   = ovf;
      w_word[STATUS_FULL_BIT]  = full;
      w_word[STATUS_EMPTY_BIT] = empty;
      w_word[STATUS_COUNT_W-1:0] = count;
      return w_word;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted only
// when a pop frees the head slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_full    = (r_count == FULL_COUNT);
   assign w_empty   = (r_count == '0);
   assign w_pop_ok  = pop && !w_empty;
   assign w_push_ok = push && (!w_full || w_pop_ok);

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;
   // Empty FIFO presents zero so the stream output is clean after reset/flush.
   assign head  = w_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok && !flush) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data-port responder: address decode, word RAM, output stream FIFO,
// sticky overflow flag and free-running cycle counter.
module data_memory_responder
   import mem_map_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int ADDR_W     = 24,
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int IDX_W  = ADDR_W - 2;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_W-1:0] CYC_ONE = DATA_W'(1);

   logic [IDX_W-1:0]  w_word_idx;
   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_unused_addr_lsbs;
   region_e           w_region;

   logic [DATA_W-1:0] r_ram [RAM_WORDS];
   logic [DATA_W-1:0] r_cycles;
   logic              r_overflow;

   logic              w_ram_we;
   logic              w_fifo_wr;
   logic              w_cyc_wr;
   logic              w_ctrl_wr;
   logic              w_flush;
   logic              w_clr_ovf;
   logic              w_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_fifo_count;
   logic [DATA_W-1:0] w_fifo_head;
   logic [DATA_W-1:0] w_read_data;

   assign w_word_idx         = addr[ADDR_W-1:2];
   assign w_ram_idx          = w_word_idx[RAM_AW-1:0];
   assign w_unused_addr_lsbs = ^addr[1:0];

   // Region decode; RAM requires every index bit above the RAM depth to be zero.
   always_comb begin
      w_region = REG_NONE;
      if (w_word_idx[IDX_W-1:RAM_AW] == '0) begin
         w_region = REG_RAM;
      end else if (w_word_idx == FIFO_DATA_ADDR[ADDR_W-1:2]) begin
         w_region = REG_FIFO;
      end else if (w_word_idx == STATUS_ADDR[ADDR_W-1:2]) begin
         w_region = REG_STATUS;
      end else if (w_word_idx == CYCLES_ADDR[ADDR_W-1:2]) begin
         w_region = REG_CYCLES;
      end else if (w_word_idx == CTRL_ADDR[ADDR_W-1:2]) begin
         w_region = REG_CTRL;
      end else begin
         w_region = REG_NONE;
      end
   end

   assign w_ram_we  = mem_write && (w_region == REG_RAM);
   assign w_fifo_wr = mem_write && (w_region == REG_FIFO);
   assign w_cyc_wr  = mem_write && (w_region == REG_CYCLES);
   assign w_ctrl_wr = mem_write && (w_region == REG_CTRL);
   assign w_flush   = w_ctrl_wr && write_data[CTRL_FLUSH_BIT];
   assign w_clr_ovf = w_ctrl_wr && write_data[CTRL_CLR_OVF_BIT];
   assign w_pop     = !w_fifo_empty && out_ready;

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_ram_idx] <= write_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycles <= '0;
      end else if (w_cyc_wr) begin
         r_cycles <= '0;
      end else begin
         r_cycles <= r_cycles + CYC_ONE;
      end
   end

   // A clear on the same edge as a dropped push wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_clr_ovf) begin
         r_overflow <= 1'b0;
      end else if (w_fifo_wr && w_fifo_full && !w_pop) begin
         r_overflow <= 1'b1;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_fifo_wr),
      .pop   (w_pop),
      .flush (w_flush),
      .wdata (write_data),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count),
      .head  (w_fifo_head)
   );

   always_comb begin
      w_read_data = '0;
      case (w_region)
         REG_RAM:    w_read_data = r_ram[w_ram_idx];
         REG_STATUS: w_read_data = pack_status(r_overflow, w_fifo_full, w_fifo_empty,
                                               STATUS_COUNT_W'(w_fifo_count));
         REG_CYCLES: w_read_data = r_cycles;
         default:    w_read_data = '0;
      endcase
   end

   assign read_data = w_read_data;
   assign out_data  = w_fifo_head;
   assign out_valid = !w_fifo_empty;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed scenarios followed by
// random traffic, checked against a queue/array reference model.
module tb_data_memory_responder;

   localparam logic [23:0] A_FIFO = 24'h800000;
   localparam logic [23:0] A_STAT = 24'h800004;
   localparam logic [23:0] A_CYC  = 24'h800008;
   localparam logic [23:0] A_CTRL = 24'h80000C;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_write;
   logic [23:0] addr;
   logic [23:0] write_data;
   logic [23:0] read_data;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready;

   data_memory_responder dut (
      .clk        (clk),
      .rst        (rst),
      .mem_write  (mem_write),
      .addr       (addr),
      .write_data (write_data),
      .read_data  (read_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic [23:0] v;
   } rd_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] m_ram [256];
   bit          m_known [256];
   int          m_count = 0;
   bit          m_ovf = 1'b0;
   logic [23:0] m_cycles = 24'h0;
   logic [23:0] exp_stream [$];
   rd_t         rd_q [$];
   bit          rd_strobe = 1'b0;

   function automatic void check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%06h required 0x%06h at %0t", name, got, exp, $time);
      end
   endfunction

   function automatic logic [23:0] model_status();
      logic [7:0] c;
      c = 8'(m_count);
      return {m_ovf, (m_count == 8), (m_count == 0), 13'h0, c};
   endfunction

   function automatic logic [23:0] model_read(input logic [23:0] a, output bit known);
      int          idx;
      logic [23:0] wa;
      idx   = int'(a >> 2);
      wa    = a & 24'hFFFFFC;
      known = 1'b1;
      if (a < 24'h800000) begin
         if (idx < 256) begin
            known = m_known[idx];
            return m_ram[idx];
         end
         return 24'h0;
      end
      if (wa == A_STAT) return model_status();
      if (wa == A_CYC) return m_cycles;
      return 24'h0;
   endfunction

   // State change of the reference model at one clock edge (pre-edge inputs).
   function automatic void model_edge(input bit we, input logic [23:0] a,
                                      input logic [23:0] wd, input bit rdy);
      int          idx;
      logic [23:0] wa;
      bit          pop;
      idx = int'(a >> 2);
      wa  = a & 24'hFFFFFC;
      pop = (m_count > 0) && rdy;
      if (we && a < 24'h800000 && idx < 256) begin
         m_ram[idx]   = wd;
         m_known[idx] = 1'b1;
      end
      m_cycles = (we && wa == A_CYC) ? 24'h0 : m_cycles + 24'h1;
      if (we && wa == A_CTRL) begin
         if (wd[0]) m_ovf = 1'b0;
         if (wd[1]) begin
            m_count = 0;
            exp_stream.delete();
         end else if (pop) begin
            m_count--;
         end
      end else if (we && wa == A_FIFO) begin
         if (m_count < 8 || pop) begin
            exp_stream.push_back(wd);
            if (!pop) m_count++;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (pop) begin
         m_count--;
      end
   endfunction

   task automatic do_cycle(input bit we, input logic [23:0] a, input logic [23:0] wd,
                           input bit rdy, input bit chk);
      bit          known;
      logic [23:0] ev;
      rd_t         r;
      mem_write  = we;
      addr       = a;
      write_data = wd;
      out_ready  = rdy;
      ev = model_read(a, known);
      rd_strobe = chk && known;
      if (rd_strobe) begin
         r.a = a;
         r.v = ev;
         rd_q.push_back(r);
      end
      @(posedge clk);
      model_edge(we, a, wd, rdy);
      #1;
      rd_strobe = 1'b0;
   endtask

   task automatic apply_reset(input int hold);
      mem_write = 1'b0;
      out_ready = 1'b0;
      rd_strobe = 1'b0;
      rst       = 1'b1;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_cycles  = 24'h0;
      exp_stream.delete();
      #1;
      check("out_valid_at_reset", {23'h0, out_valid}, 24'h0);
      check("out_data_at_reset", out_data, 24'h0);
      repeat (hold) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: stream handshake and scheduled reads, sampled mid-cycle.
   always @(negedge clk) begin : monitor
      rd_t r;
      check("out_valid", {23'h0, out_valid}, {23'h0, (m_count != 0)});
      if (m_count != 0 && exp_stream.size() != 0) begin
         check("out_data", out_data, exp_stream[0]);
         if (out_ready) void'(exp_stream.pop_front());
      end
      if (rd_strobe && rd_q.size() != 0) begin
         r = rd_q.pop_front();
         check($sformatf("read_data@%06h", r.a), read_data, r.v);
      end
   end

   initial begin
      mem_write  = 1'b0;
      addr       = 24'h0;
      write_data = 24'h0;
      out_ready  = 1'b0;
      apply_reset(2);

      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);

      // RAM store/load, ignored low address bits, out-of-range word
      do_cycle(1'b1, 24'h000010, 24'h123456, 1'b0, 1'b0);
      do_cycle(1'b0, 24'h000010, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, 24'h000013, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, 24'h000400, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b1, 24'h000010, 24'h654321, 1'b0, 1'b1);
      do_cycle(1'b0, 24'h000010, 24'h0, 1'b0, 1'b1);

      // Fill, overflow, clear overflow
      for (int i = 1; i <= 8; i++) do_cycle(1'b1, A_FIFO, 24'(i), 1'b0, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b1, A_FIFO, 24'd9, 1'b0, 1'b0);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b1, A_CTRL, 24'h1, 1'b0, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);

      // Push+pop at full, then drain 2..9
      do_cycle(1'b1, A_FIFO, 24'd9, 1'b1, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) do_cycle(1'b0, A_STAT, 24'h0, 1'b1, 1'b1);

      // Cycle counter: reset after 100 cycles, write-wins-over-increment
      repeat (100) do_cycle(1'b0, 24'h000000, 24'h0, 1'b0, 1'b0);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);
      apply_reset(2);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b1, A_CYC, 24'h5A5A5A, 1'b0, 1'b1);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, A_CYC, 24'h0, 1'b0, 1'b1);

      // Flush beats a same-edge pop
      for (int i = 0; i < 3; i++) do_cycle(1'b1, A_FIFO, 24'hA00 + 24'(i), 1'b0, 1'b0);
      do_cycle(1'b1, A_CTRL, 24'h2, 1'b1, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b1, 1'b1);

      // Reset mid-stream keeps RAM
      do_cycle(1'b1, 24'h000020, 24'hABCDEF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_cycle(1'b1, A_FIFO, 24'hB00 + 24'(i), 1'b0, 1'b0);
      apply_reset(3);
      do_cycle(1'b0, 24'h000020, 24'h0, 1'b0, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         int          op;
         logic [23:0] a;
         logic [23:0] d;
         bit          we;
         bit          rdy;
         op  = $urandom_range(0, 9);
         d   = 24'($urandom);
         rdy = 1'($urandom_range(0, 1));
         we  = 1'b0;
         a   = 24'($urandom_range(0, 63));
         case (op)
            0, 1: we = 1'b1;
            2: begin
               we = 1'b1;
               a  = 24'h000400 + 24'($urandom_range(0, 4095));
            end
            3: we = 1'b0;
            4, 5: begin
               we = 1'b1;
               a  = A_FIFO | 24'($urandom_range(0, 3));
            end
            6: begin
               we = 1'($urandom_range(0, 1));
               a  = A_STAT | 24'($urandom_range(0, 3));
            end
            7: begin
               we = ($urandom_range(0, 15) == 0);
               a  = A_CYC;
            end
            8: begin
               we = 1'b1;
               a  = A_CTRL;
               d  = {22'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
            end
            default: begin
               we = 1'($urandom_range(0, 1));
               a  = ($urandom_range(0, 1) == 0) ? 24'h900000 : 24'h800010 + 24'($urandom_range(0, 255)) * 24'd4;
            end
         endcase
         do_cycle(we, a, d, rdy, 1'b1);
      end

      for (int k = 0; k < 20 && m_count != 0; k++) do_cycle(1'b0, A_STAT, 24'h0, 1'b1, 1'b1);
      do_cycle(1'b0, A_STAT, 24'h0, 1'b0, 1'b1);
      check("drain_out_valid", {23'h0, out_valid}, 24'h0);
      check("pending_reads", 24'(rd_q.size()), 24'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
